// File: rtl/cdr_phase_controller_if.sv
// Vote and step signals between the bang-bang phase detector side and the CDR loop controller.
// The detector side (master) supplies votes; the controller (slave) returns step requests and status.
interface cdr_phase_controller_if #(
  parameter int ACC_W = 6
);
  logic             en;
  logic             vote_valid;
  logic             early;
  logic             late;
  logic             shift_right;
  logic             shift_left;
  logic [3:0]       tap_idx;
  logic [ACC_W-1:0] acc;
  logic             holdoff;
  logic             locked;

  modport master (
    output en, vote_valid, early, late,
    input  shift_right, shift_left, tap_idx, acc, holdoff, locked
  );

  modport slave (
    input  en, vote_valid, early, late,
    output shift_right, shift_left, tap_idx, acc, holdoff, locked
  );
endinterface

// File: rtl/cdr_phase_controller.sv
// CDR loop controller: integrates early/late votes, issues single-cycle tap steps,
// waits for the delay line to settle, and tracks a shadow tap index and lock status.
module cdr_phase_controller #(
  parameter int ACC_W    = 6,
  parameter int THRESH   = 16,
  parameter int HOLDOFF  = 20,
  parameter int LOCK_WIN = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  cdr_phase_controller_if.slave    bus
);

  typedef enum logic {TRACK, HOLD} state_t;

  localparam int HOLD_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int LOCK_W  = $clog2(LOCK_WIN + 1);
  localparam int ACC_MAX = (1 <<< (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 <<< (ACC_W - 1));

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [HOLD_W-1:0]        hold_cnt, hold_d;
  logic [LOCK_W-1:0]        lock_cnt, lock_d;
  logic [3:0]               tap_q, tap_d;
  logic                     sl_q, sl_d;
  logic                     sr_q, sr_d;
  logic                     locked_q, locked_d;
  logic                     holdoff_q, holdoff_d;
  int                       vote;
  int                       acc_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TRACK;
      acc_q     <= '0;
      hold_cnt  <= '0;
      lock_cnt  <= '0;
      tap_q     <= '0;
      sl_q      <= 1'b0;
      sr_q      <= 1'b0;
      locked_q  <= 1'b0;
      holdoff_q <= 1'b0;
    end else begin
      state     <= state_next;
      acc_q     <= acc_d;
      hold_cnt  <= hold_d;
      lock_cnt  <= lock_d;
      tap_q     <= tap_d;
      sl_q      <= sl_d;
      sr_q      <= sr_d;
      locked_q  <= locked_d;
      holdoff_q <= holdoff_d;
    end
  end

  always_comb begin
    state_next = state;
    acc_d      = acc_q;
    hold_d     = hold_cnt;
    lock_d     = lock_cnt;
    tap_d      = tap_q;
    sl_d       = 1'b0;
    sr_d       = 1'b0;
    locked_d   = locked_q;
    holdoff_d  = (state == HOLD);
    vote       = 0;
    acc_sat    = 0;

    if (bus.vote_valid && bus.late && !bus.early) begin
      vote = 1;
    end else if (bus.vote_valid && bus.early && !bus.late) begin
      vote = -1;
    end

    acc_sat = int'(acc_q) + vote;
    if (acc_sat > ACC_MAX) begin
      acc_sat = ACC_MAX;
    end else if (acc_sat < ACC_MIN) begin
      acc_sat = ACC_MIN;
    end

    // The shadow tap follows the pulse the delay line sees on this edge.
    if (bus.en) begin
      tap_d = tap_q + 4'(sl_q) - 4'(sr_q);
      case (state)
        TRACK: begin
          if (acc_sat >= THRESH || acc_sat <= -THRESH) begin
            sl_d       = (acc_sat >= THRESH);
            sr_d       = (acc_sat <= -THRESH);
            acc_d      = '0;
            hold_d     = HOLD_W'(HOLDOFF - 1);
            lock_d     = '0;
            locked_d   = 1'b0;
            state_next = HOLD;
          end else begin
            acc_d = acc_sat[ACC_W-1:0];
            if (lock_cnt != LOCK_W'(LOCK_WIN)) begin
              lock_d = lock_cnt + LOCK_W'(1);
            end
            locked_d = (lock_d == LOCK_W'(LOCK_WIN));
          end
        end
        HOLD: begin
          acc_d = '0;
          if (hold_cnt == '0) begin
            state_next = TRACK;
          end else begin
            hold_d = hold_cnt - HOLD_W'(1);
          end
        end
        default: state_next = TRACK;
      endcase
    end
  end

  assign bus.shift_left  = sl_q;
  assign bus.shift_right = sr_q;
  assign bus.tap_idx     = tap_q;
  assign bus.acc         = acc_q;
  assign bus.holdoff     = holdoff_q;
  assign bus.locked      = locked_q;

endmodule
